// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO that launches queued bytes into a serial transmitter over a tx_start/tx_busy handshake.
// Optional feature (define UART_TX_CHECKSUM_EN): an XOR checksum byte follows every byte written with wr_last.
module uart_tx_queue #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     wr_last,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_TX_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        CKSUM     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;
`endif

    state_t          state_r;
    state_t          state_next_s;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wptr_r;
    logic [AW-1:0]   rptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_next_s;
    logic            full_r;
    logic            empty_r;
    logic            overflow_r;
    logic            tx_start_r;
    logic [7:0]      tx_data_r;
    logic            push_s;
    logic            pop_s;
    logic            launch_s;
    logic [7:0]      launch_data_s;
    logic [7:0]      rd_data_s;

`ifdef UART_TX_CHECKSUM_EN
    logic            last_mem_r [DEPTH];
    logic [7:0]      acc_r;
    logic            last_pend_r;
    logic            ck_launch_s;

    function automatic logic [7:0] cksum_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction
`else
    logic            unused_last_s;
    assign unused_last_s = wr_last;
`endif

    // Full is the registered flag, so a write while full is dropped even if a pop frees a slot this cycle.
    assign push_s    = wr_en && !full_r;
    assign rd_data_s = mem_r[rptr_r];

    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;

    // Launch FSM: next state, pop request and the byte to present to the transmitter
    always_comb begin
        state_next_s  = state_r;
        pop_s         = 1'b0;
        launch_s      = 1'b0;
        launch_data_s = tx_data_r;
`ifdef UART_TX_CHECKSUM_EN
        ck_launch_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (!empty_r && !tx_busy) begin
                    pop_s         = 1'b1;
                    launch_s      = 1'b1;
                    launch_data_s = rd_data_s;
                    state_next_s  = WAIT_BUSY;
                end else begin
                    state_next_s  = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next_s = WAIT_DONE;
                end else begin
                    state_next_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_TX_CHECKSUM_EN
                    if (last_pend_r) begin
                        state_next_s = CKSUM;
                    end else begin
                        state_next_s = IDLE;
                    end
`else
                    state_next_s = IDLE;
`endif
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
`ifdef UART_TX_CHECKSUM_EN
            CKSUM: begin
                if (!tx_busy) begin
                    launch_s      = 1'b1;
                    ck_launch_s   = 1'b1;
                    launch_data_s = acc_r;
                    state_next_s  = WAIT_BUSY;
                end else begin
                    state_next_s  = CKSUM;
                end
            end
`endif
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Occupancy: a push and pop in the same cycle cancel out
    always_comb begin
        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1'b1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CW'(1'b1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wptr_r] <= wr_data;
`ifdef UART_TX_CHECKSUM_EN
            last_mem_r[wptr_r] <= wr_last;
`endif
        end
    end

    // Control state, pointers, flags and transmitter outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wptr_r     <= {AW{1'b0}};
            rptr_r     <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else begin
            state_r    <= state_next_s;
            tx_start_r <= launch_s;
            tx_data_r  <= launch_data_s;
            overflow_r <= wr_en && full_r;
            count_r    <= count_next_s;
            full_r     <= (count_next_s == CW'(DEPTH));
            empty_r    <= (count_next_s == {CW{1'b0}});
            if (push_s) begin
                wptr_r <= wptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1'b1);
            end
        end
    end

`ifdef UART_TX_CHECKSUM_EN
    // Packet checksum: folds in each popped byte and remembers whether it closed a packet
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= 8'h00;
            last_pend_r <= 1'b0;
        end else if (ck_launch_s) begin
            acc_r       <= 8'h00;
            last_pend_r <= 1'b0;
        end else if (pop_s) begin
            acc_r       <= cksum_fold(acc_r, rd_data_s);
            last_pend_r <= last_mem_r[rptr_r];
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: vector table, directed handshake sequences, and random traffic
// checked against a queue model of the byte stream the transmitter should receive.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   wr_en = 1'b0;
    logic [7:0]             wr_data = 8'h00;
    logic                   wr_last = 1'b0;
    logic                   tx_busy = 1'b0;
    logic                   full;
    logic                   empty;
    logic                   overflow;
    logic                   tx_start;
    logic [$clog2(DEPTH):0] count;
    logic [7:0]             tx_data;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_v;
        logic       wr_en;
        logic [7:0] data;
        logic       force_b;
        int         exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
        logic       exp_start;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       tbl[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_start = -100;
    int         busy_cnt = 0;
    int         busy_len = 4;
    bit         rand_busy = 1'b0;
    logic       force_busy = 1'b0;
    logic [8:0] exp_q[$];
    int         m_cnt = 0;
    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_last_tx = 8'h00;
    logic [7:0] log_d[$];
    int         log_c[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: advance, check outputs against the stream model, then run the transmitter model.
    task automatic tick();
        logic       busy_seen;
        logic       acc_ok;
        logic       exp_ovf;
        logic [8:0] item;
        busy_seen = tx_busy;
        acc_ok    = wr_en && (m_cnt != DEPTH);
        exp_ovf   = wr_en && (m_cnt == DEPTH);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            chk("rst_tx_start", tx_start, 0);
            chk("rst_overflow", overflow, 0);
            exp_q.delete();
            m_cnt      = 0;
            m_acc      = 8'h00;
            m_last_tx  = 8'h00;
            last_start = -100;
        end else begin
            if (tx_start) begin
                chk("start_while_busy", busy_seen, 0);
                chk("start_gap_ok", int'(cyc - last_start >= 3), 1);
                chk("start_has_pending", int'(exp_q.size() > 0), 1);
                last_start = cyc;
                log_d.push_back(tx_data);
                log_c.push_back(cyc);
                if (exp_q.size() > 0) begin
                    item = exp_q.pop_front();
                    chk("tx_data_order", tx_data, item[7:0]);
                    m_last_tx = item[7:0];
                    if (!item[8]) m_cnt--;
                end
            end
            chk("overflow", overflow, exp_ovf);
            if (acc_ok) begin
                exp_q.push_back({1'b0, wr_data});
                m_cnt++;
`ifdef UART_TX_CHECKSUM_EN
                m_acc = m_acc ^ wr_data;
                if (wr_last) begin
                    exp_q.push_back({1'b1, m_acc});
                    m_acc = 8'h00;
                end
`endif
            end
        end
        chk("count", count, m_cnt);
        chk("full", full, int'(m_cnt == DEPTH));
        chk("empty", empty, int'(m_cnt == 0));
        chk("tx_data_hold", tx_data, m_last_tx);
        if (busy_cnt > 0) busy_cnt--;
        if (tx_start) busy_cnt = rand_busy ? int'($urandom_range(1, 6)) : busy_len;
        tx_busy = force_busy || (busy_cnt > 0);
    endtask

    task automatic drive(input logic r, input logic we, input logic [7:0] d, input logic l, input logic fb);
        rst        = r;
        wr_en      = we;
        wr_data    = d;
        wr_last    = l;
        force_busy = fb;
        tx_busy    = fb || (busy_cnt > 0);
    endtask

    task automatic do_reset();
        int n = 0;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        while (tx_busy && n < 50) begin
            tick();
            n++;
        end
        chk("reset_quiet", tx_busy, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", int'(exp_q.size() == 0 && !tx_busy), 1);
        tick();
        tick();
    endtask

    task automatic add(input logic r, input logic we, input logic [7:0] d, input logic fb, input int c,
                       input logic f, input logic e, input logic o, input logic s, input logic [7:0] td);
        tbl.push_back('{r, we, d, fb, c, f, e, o, s, td});
    endtask

    initial begin
        int n0;
        logic fb;
        // Vectors: fill to full with the transmitter held busy, overflow, pop while full, push+pop at count 5
        add(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= DEPTH; i++)
            add(1'b0, 1'b1, 8'(i), 1'b1, i, (i == DEPTH), 1'b0, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 8'hEE, 1'b1, 16, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        add(1'b0, 1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 8'hEF, 1'b0, 15, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01);
        add(1'b0, 1'b0, 8'h00, 1'b0, 15, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        add(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 5; i++)
            add(1'b0, 1'b1, 8'(8'h30 + i), 1'b1, i, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 8'h36, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31);
        add(1'b0, 1'b0, 8'h00, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h31);

        busy_len = 4;
        foreach (tbl[i]) begin
            drive(tbl[i].rst_v, tbl[i].wr_en, tbl[i].data, 1'b0, tbl[i].force_b);
            tick();
            chk($sformatf("vec%0d_count", i), count, tbl[i].exp_count);
            chk($sformatf("vec%0d_full", i), full, tbl[i].exp_full);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].exp_empty);
            chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].exp_ovf);
            chk($sformatf("vec%0d_tx_start", i), tx_start, tbl[i].exp_start);
            chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].exp_data);
        end

        // Single byte into an empty idle queue: launch one cycle after the write edge
        busy_len = 10;
        do_reset();
        drive(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        tick();
        chk("a5_count_after_write", count, 1);
        chk("a5_no_early_start", tx_start, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("a5_tx_start", tx_start, 1);
        chk("a5_tx_data", tx_data, 8'hA5);
        chk("a5_count_zero", count, 0);
        tick();
        chk("a5_start_one_cycle", tx_start, 0);
        wait_drain(200);

        // Three bytes, transmitter busy 10 cycles each
        do_reset();
        log_d.delete();
        log_c.delete();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            tick();
        end
        wait_drain(300);
        chk("seq3_launches", log_d.size(), 3);
        if (log_d.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("seq3_byte%0d", i), log_d[i], i + 1);
            chk("seq3_gap01", int'(log_c[1] - log_c[0] >= 11), 1);
            chk("seq3_gap12", int'(log_c[2] - log_c[1] >= 11), 1);
        end

        // Packet 12, 34(last): checksum 26 appended only when the feature is built in
        busy_len = 3;
        do_reset();
        log_d.delete();
        log_c.delete();
        drive(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'h34, 1'b1, 1'b0);
        tick();
        wait_drain(300);
`ifdef UART_TX_CHECKSUM_EN
        chk("pkt_launches", log_d.size(), 3);
        if (log_d.size() == 3) chk("pkt_cksum", log_d[2], 8'h26);
`else
        chk("pkt_launches", log_d.size(), 2);
`endif
        if (log_d.size() >= 2) begin
            chk("pkt_byte0", log_d[0], 8'h12);
            chk("pkt_byte1", log_d[1], 8'h34);
        end

        // Reset with 7 queued while waiting for the transmitter to finish
        busy_len = 10;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            tick();
        end
        chk("rst7_count_before", count, 7);
        drive(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        tick();
        chk("rst7_count", count, 0);
        chk("rst7_empty", empty, 1);
        chk("rst7_tx_start", tx_start, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n0 = log_d.size();
        repeat (20) tick();
        chk("rst7_no_launch", log_d.size(), n0);
        drive(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("rst7_idle_launch", tx_start, 1);
        chk("rst7_idle_data", tx_data, 8'h77);
        wait_drain(200);

        // Random traffic with random transmitter timing, busy bursts and occasional resets
        rand_busy = 1'b1;
        do_reset();
        fb = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) fb = !fb;
            drive(($urandom_range(0, 599) == 0), ($urandom_range(0, 99) < 45), 8'($urandom),
                  ($urandom_range(0, 3) == 0), fb);
            tick();
        end
        wait_drain(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count (power of 2, range 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wr_en  input  1  write strobe; pushes wr_data when accepted.
REQ-005 SHALL have port wr_data  input  8  byte to queue.
REQ-006 SHALL have port wr_last  input  1  marks the written byte as end of packet.
REQ-007 SHALL have port full  output  1  high when count==DEPTH.
REQ-008 SHALL have port empty  output  1  high when count==0.
REQ-009 SHALL have port count  output  log2(DEPTH)+1  number of bytes currently stored.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 SHALL have port tx_start  output  1  one-cycle launch pulse to the serial transmitter.
REQ-012 SHALL have port tx_data  output  8  byte for the transmitter; stable from tx_start until the next launch.
REQ-013 SHALL have port tx_busy  input  1  transmitter busy flag.

Function
REQ-014 SHALL accept a write iff wr_en && !full (registered full); accepted byte stored with its wr_last bit.
REQ-015 SHALL drop a write when wr_en && full, including when a pop occurs in the same cycle, and pulse overflow the next cycle.
REQ-016 SHALL update count to +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-017 SHALL wrap the read and write pointers modulo DEPTH.
REQ-018 SHALL implement the FSM states IDLE, WAIT_BUSY, WAIT_DONE, and CKSUM (CKSUM only with the macro).
REQ-019 In IDLE, when !empty && !tx_busy, SHALL pop one byte, load tx_data, assert tx_start for exactly 1 cycle, and go to WAIT_BUSY.
REQ-020 In WAIT_BUSY, SHALL go to WAIT_DONE when tx_busy==1.
REQ-021 In WAIT_DONE, SHALL return to IDLE when tx_busy==0 (or to CKSUM per REQ-031).
REQ-022 SHALL have a minimum gap of 3 cycles between consecutive tx_start pulses.
REQ-023 SHALL keep the latency from a write into an empty, idle queue (tx_busy low) to tx_start at 1 cycle: byte written at edge N, tx_start high after edge N+1.
REQ-024 SHALL never assert tx_start while tx_busy==1 or while in WAIT_BUSY, WAIT_DONE, or CKSUM.
REQ-025 SHALL leave the FIFO contents and count unchanged when in WAIT_BUSY or WAIT_DONE, except for pushes.

Reset
REQ-026 On rst, SHALL set state=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00, and checksum accumulator=8'h00.
REQ-027 SHALL discard queued bytes on rst asserted mid-operation; a transfer already launched completes in the transmitter unaffected.
REQ-028 SHALL ignore writes in the cycle that rst is high.

Configuration
REQ-029 SHALL use the macro UART_TX_CHECKSUM_EN.
REQ-030 With UART_TX_CHECKSUM_EN defined, SHALL XOR each popped byte into an 8-bit accumulator.
REQ-031 With UART_TX_CHECKSUM_EN defined, after the WAIT_DONE of a byte popped with last=1, SHALL enter CKSUM, and then, when !tx_busy, launch the accumulator value as tx_data with a tx_start pulse, clear the accumulator, and go to WAIT_BUSY; checksum launch precedes any further FIFO pop.
REQ-032 Without UART_TX_CHECKSUM_EN, SHALL ignore wr_last, omit the CKSUM state and the accumulator, and transmit only the queued bytes.

Verification
REQ-033 SHALL verify: write 8'hA5 into an empty queue, tx_busy low -> tx_start pulses 1 cycle later with tx_data=8'hA5, count returns to 0.
REQ-034 SHALL verify: write DEPTH bytes with tx_busy held high -> full=1, count=DEPTH; a 17th write (DEPTH=16) -> overflow pulse and count stays 16.
REQ-035 SHALL verify: push and pop in the same cycle with count=5 -> count stays 5; a write while full with a simultaneous pop -> dropped, overflow=1.
REQ-036 SHALL verify: bytes 8'h01, 8'h02, 8'h03 with transmitter model busy 10 cycles per byte -> three tx_start pulses in order, each only after tx_busy falls.
REQ-037 SHALL verify: with UART_TX_CHECKSUM_EN, bytes 8'h12, 8'h34 (last=1) -> transmits 8'h12, 8'h34, 8'h26; without the macro -> 8'h12, 8'h34 only.
REQ-038 SHALL verify: rst asserted with count=7 in WAIT_DONE -> next cycle count=0, empty=1, state IDLE, and no tx_start after the transmitter goes idle.
